// File: rtl/rpn_eval_ctrl.sv
// ---------------------------------------------------------------------------
// rpn_eval_ctrl
//
// Evaluates a postfix (RPN) token stream.  Operands are pushed onto an
// internal register stack.  Each arithmetic operator pops the two top
// entries, sends them to a shared external ALU over a strobe/ack handshake
// and pushes the ALU result back.  "=" hands the single remaining stack
// entry to the consumer.  Any malformed stream produces an error code on
// the output port instead and discards the whole expression.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   I_DAT        token: operand value, or ASCII operator in the low byte
//   I_NUM_OR_OP  1 = operand, 0 = operator
//   I_STB/I_ACK  token handshake, consumed when both are high on an edge
//   A_STB        ALU request, held until A_ACK
//   A_OPA/A_OPB  deeper / top stack operand
//   A_OP         0 = add, 1 = sub, 2 = mul
//   A_ACK/A_RES  ALU done, result valid in the same cycle
//   O_STB/O_ACK  output handshake
//   O_DAT/O_ERR  result value, or error code when O_ERR = 1
//   O_SP         current stack depth
//
// Error codes: 1 underflow, 2 overflow, 3 bad operator, 4 unbalanced "=".
// ---------------------------------------------------------------------------
module rpn_eval_ctrl #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] I_DAT,
  input  logic         I_NUM_OR_OP,
  input  logic         I_STB,
  output logic         I_ACK,
  output logic         A_STB,
  output logic [W-1:0] A_OPA,
  output logic [W-1:0] A_OPB,
  output logic [1:0]   A_OP,
  input  logic         A_ACK,
  input  logic [W-1:0] A_RES,
  output logic         O_STB,
  output logic [W-1:0] O_DAT,
  output logic         O_ERR,
  input  logic         O_ACK,
  output logic [7:0]   O_SP
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ALU  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_OVER  = 3'd2;
  localparam logic [2:0] ERR_BADOP = 3'd3;
  localparam logic [2:0] ERR_UNBAL = 3'd4;

  logic [1:0]   state;
  logic [7:0]   sp;
  logic [W-1:0] stk [DEPTH];
  logic [W-1:0] opa_q;
  logic [W-1:0] opb_q;
  logic [1:0]   op_q;
  logic [W-1:0] o_dat_q;
  logic         o_err_q;

  logic [AW-1:0] idx_push;
  logic [AW-1:0] idx_top;
  logic [AW-1:0] idx_sec;

  logic         is_arith;
  logic         is_eq;
  logic [1:0]   arith_code;
  logic [2:0]   err_code;

  logic          stk_we;
  logic [AW-1:0] stk_widx;
  logic [W-1:0]  stk_wdata;

  // Handshake outputs are pure state decodes so they never depend on the
  // incoming strobes.
  assign I_ACK = (state == ST_IDLE);
  assign A_STB = (state == ST_ALU);
  assign O_STB = (state == ST_OUT);
  assign A_OPA = opa_q;
  assign A_OPB = opb_q;
  assign A_OP  = op_q;
  assign O_DAT = o_dat_q;
  assign O_ERR = o_err_q;
  assign O_SP  = sp;

  // Stack pointer derived indices; truncation is safe because each index is
  // only used when sp guarantees it is in range.
  assign idx_push = AW'(sp);
  assign idx_top  = AW'(sp - 8'd1);
  assign idx_sec  = AW'(sp - 8'd2);

  // Operator decode on the low byte and the error a token would raise if it
  // were accepted now.  Errors take priority over any normal action.
  always_comb begin
    is_arith   = 1'b0;
    is_eq      = 1'b0;
    arith_code = 2'd0;
    err_code   = ERR_NONE;
    case (I_DAT[7:0])
      8'h2B: begin is_arith = 1'b1; arith_code = 2'd0; end
      8'h2D: begin is_arith = 1'b1; arith_code = 2'd1; end
      8'h2A: begin is_arith = 1'b1; arith_code = 2'd2; end
      8'h3D: is_eq = 1'b1;
      default: ;
    endcase
    if (I_NUM_OR_OP) begin
      if (sp >= DEPTH_L) err_code = ERR_OVER;
    end else if (is_arith) begin
      if (sp < 8'd2) err_code = ERR_UNDER;
    end else if (is_eq) begin
      if (sp != 8'd1) err_code = ERR_UNBAL;
    end else begin
      err_code = ERR_BADOP;
    end
  end

  // Single stack write port: operand push in IDLE, or the ALU result
  // replacing the deeper operand when the ALU acknowledges.
  always_comb begin
    stk_we    = 1'b0;
    stk_widx  = idx_push;
    stk_wdata = I_DAT;
    if (state == ST_IDLE && I_STB && I_NUM_OR_OP && sp < DEPTH_L) begin
      stk_we = 1'b1;
    end else if (state == ST_ALU && A_ACK) begin
      stk_we    = 1'b1;
      stk_widx  = idx_sec;
      stk_wdata = A_RES;
    end
  end

  // Stack storage has no reset; its contents are meaningless once sp is 0.
  always_ff @(posedge CLK) begin
    if (stk_we) stk[stk_widx] <= stk_wdata;
  end

  // Control FSM.  Any error forces sp to 0 so the rest of a broken
  // expression is thrown away.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      sp      <= 8'd0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= 2'd0;
      o_dat_q <= '0;
      o_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_STB) begin
            if (err_code != ERR_NONE) begin
              o_dat_q <= {{(W-3){1'b0}}, err_code};
              o_err_q <= 1'b1;
              sp      <= 8'd0;
              state   <= ST_OUT;
            end else if (I_NUM_OR_OP) begin
              sp <= sp + 8'd1;
            end else if (is_arith) begin
              opa_q <= stk[idx_sec];
              opb_q <= stk[idx_top];
              op_q  <= arith_code;
              state <= ST_ALU;
            end else begin
              o_dat_q <= stk[0];
              o_err_q <= 1'b0;
              sp      <= 8'd0;
              state   <= ST_OUT;
            end
          end
        end
        ST_ALU: begin
          if (A_ACK) begin
            sp    <= sp - 8'd1;
            state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (O_ACK) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rpn_eval_ctrl
//
// Self-checking bench for rpn_eval_ctrl.  Expected ALU requests and expected
// output words are pushed to queues as each expression is driven, and are
// popped and compared when the DUT raises A_STB or O_STB.  The ALU itself is
// modelled here, computing results from the expected operands.
// ---------------------------------------------------------------------------
module tb_rpn_eval_ctrl;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [1:0]   op;
  } alu_req_t;

  typedef struct packed {
    logic         err;
    logic [W-1:0] dat;
  } out_t;

  logic         CLK;
  logic         RST;
  logic [W-1:0] I_DAT;
  logic         I_NUM_OR_OP;
  logic         I_STB;
  logic         I_ACK;
  logic         A_STB;
  logic [W-1:0] A_OPA;
  logic [W-1:0] A_OPB;
  logic [1:0]   A_OP;
  logic         A_ACK;
  logic [W-1:0] A_RES;
  logic         O_STB;
  logic [W-1:0] O_DAT;
  logic         O_ERR;
  logic         O_ACK;
  logic [7:0]   O_SP;

  alu_req_t alu_q[$];
  out_t     out_q[$];
  int       checks = 0;
  int       errors = 0;

  rpn_eval_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .I_DAT(I_DAT), .I_NUM_OR_OP(I_NUM_OR_OP), .I_STB(I_STB), .I_ACK(I_ACK),
    .A_STB(A_STB), .A_OPA(A_OPA), .A_OPB(A_OPB), .A_OP(A_OP),
    .A_ACK(A_ACK), .A_RES(A_RES),
    .O_STB(O_STB), .O_DAT(O_DAT), .O_ERR(O_ERR), .O_ACK(O_ACK), .O_SP(O_SP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      default: return a * b;
    endcase
  endfunction

  function automatic logic [W-1:0] op_token(input logic [1:0] op);
    case (op)
      2'd0:    return 32'h2B;
      2'd1:    return 32'h2D;
      default: return 32'h2A;
    endcase
  endfunction

  // Presents one token and returns one cycle after it is consumed.
  task automatic send_token(input logic num, input logic [W-1:0] val);
    int n = 0;
    I_DAT = val;
    I_NUM_OR_OP = num;
    I_STB = 1'b1;
    while (I_ACK !== 1'b1 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (I_ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL token_accept got I_ACK=%b exp 1", I_ACK);
    end
    @(posedge CLK); #1;
    I_STB = 1'b0;
  endtask

  // Answers one ALU request after 'delay' wait cycles.
  task automatic serve_alu(input int delay);
    alu_req_t e;
    int n = 0;
    while (A_STB !== 1'b1 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (A_STB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alu_request got A_STB=%b exp 1", A_STB);
      return;
    end
    checks++;
    if (alu_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL alu_unexpected got request exp none");
      return;
    end
    e = alu_q.pop_front();
    checks++;
    if (A_OPA !== e.opa || A_OPB !== e.opb || A_OP !== e.op || I_ACK !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_operands got %0h %0h op%0d ack%b exp %0h %0h op%0d ack0",
               A_OPA, A_OPB, A_OP, I_ACK, e.opa, e.opb, e.op);
    end
    repeat (delay) begin
      @(posedge CLK); #1;
      checks++;
      if (A_STB !== 1'b1 || A_OPA !== e.opa || A_OPB !== e.opb || A_OP !== e.op) begin
        errors++;
        $display("[TB] FAIL alu_hold got stb%b %0h %0h op%0d exp stb1 %0h %0h op%0d",
                 A_STB, A_OPA, A_OPB, A_OP, e.opa, e.opb, e.op);
      end
    end
    A_RES = alu_model(e.opa, e.opb, e.op);
    A_ACK = 1'b1;
    @(posedge CLK); #1;
    A_ACK = 1'b0;
    A_RES = '0;
    checks++;
    if (A_STB !== 1'b0 || I_ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alu_release got stb%b iack%b exp stb0 iack1", A_STB, I_ACK);
    end
  endtask

  // Waits for O_STB, compares, holds O_ACK low for 'hold' cycles, then acks.
  task automatic collect_output(input int hold);
    out_t e;
    int n = 0;
    while (O_STB !== 1'b1 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (O_STB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL out_strobe got O_STB=%b exp 1", O_STB);
      return;
    end
    checks++;
    if (out_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL out_unexpected got output exp none");
      return;
    end
    e = out_q.pop_front();
    checks++;
    if (O_DAT !== e.dat || O_ERR !== e.err || I_ACK !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_value got dat%0h err%b iack%b exp dat%0h err%b iack0",
               O_DAT, O_ERR, I_ACK, e.dat, e.err);
    end
    repeat (hold) begin
      @(posedge CLK); #1;
      checks++;
      if (O_STB !== 1'b1 || O_DAT !== e.dat || O_ERR !== e.err || I_ACK !== 1'b0) begin
        errors++;
        $display("[TB] FAIL out_hold got stb%b dat%0h err%b iack%b exp stb1 dat%0h err%b iack0",
                 O_STB, O_DAT, O_ERR, I_ACK, e.dat, e.err);
      end
    end
    O_ACK = 1'b1;
    @(posedge CLK); #1;
    O_ACK = 1'b0;
    checks++;
    if (O_STB !== 1'b0 || O_SP !== 8'd0 || I_ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL out_release got stb%b sp%0d iack%b exp stb0 sp0 iack1",
               O_STB, O_SP, I_ACK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (A_STB !== 1'b0 || A_OPA !== '0 || A_OPB !== '0 || A_OP !== 2'd0 ||
        O_STB !== 1'b0 || O_DAT !== '0 || O_ERR !== 1'b0 || O_SP !== 8'd0 ||
        I_ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state got astb%b opa%0h opb%0h op%0d ostb%b dat%0h err%b sp%0d iack%b exp all 0 iack1",
               A_STB, A_OPA, A_OPB, A_OP, O_STB, O_DAT, O_ERR, O_SP, I_ACK);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_add();
    alu_q.push_back('{opa: 32'd3, opb: 32'd4, op: 2'd0});
    out_q.push_back('{err: 1'b0, dat: 32'd7});
    send_token(1'b1, 32'd3);
    checks++;
    if (O_SP !== 8'd1) begin
      errors++;
      $display("[TB] FAIL add_sp got %0d exp 1", O_SP);
    end
    send_token(1'b1, 32'd4);
    send_token(1'b0, 32'h2B);
    serve_alu(2);
    send_token(1'b0, 32'h3D);
    checks++;
    if (O_STB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL eq_latency got O_STB=%b exp 1", O_STB);
    end
    collect_output(0);
  endtask

  task automatic test_sub_mul();
    alu_q.push_back('{opa: 32'd10, opb: 32'd4, op: 2'd1});
    alu_q.push_back('{opa: 32'd6, opb: 32'd2, op: 2'd2});
    out_q.push_back('{err: 1'b0, dat: 32'd12});
    send_token(1'b1, 32'd10);
    send_token(1'b1, 32'd4);
    send_token(1'b0, 32'h2D);
    serve_alu(1);
    send_token(1'b1, 32'd2);
    send_token(1'b0, 32'h2A);
    serve_alu(0);
    send_token(1'b0, 32'h3D);
    collect_output(0);
  endtask

  task automatic test_underflow_recovery();
    out_q.push_back('{err: 1'b1, dat: 32'd1});
    send_token(1'b1, 32'd5);
    send_token(1'b0, 32'h2B);
    collect_output(0);
    alu_q.push_back('{opa: 32'd1, opb: 32'd1, op: 2'd0});
    out_q.push_back('{err: 1'b0, dat: 32'd2});
    send_token(1'b1, 32'd1);
    send_token(1'b1, 32'd1);
    send_token(1'b0, 32'h2B);
    serve_alu(2);
    send_token(1'b0, 32'h3D);
    collect_output(0);
  endtask

  task automatic test_back_to_back_overflow();
    out_q.push_back('{err: 1'b1, dat: 32'd2});
    I_NUM_OR_OP = 1'b1;
    I_STB = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      checks++;
      if (I_ACK !== 1'b1 || O_SP !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL push_stream got iack%b sp%0d exp iack1 sp%0d", I_ACK, O_SP, i);
      end
      I_DAT = 32'(100 + i);
      @(posedge CLK); #1;
    end
    I_STB = 1'b0;
    collect_output(0);
  endtask

  task automatic test_full_stack();
    logic [W-1:0] run = 32'd8;
    for (int k = 1; k <= DEPTH; k++) send_token(1'b1, 32'(k));
    for (int k = DEPTH - 1; k >= 1; k--) begin
      alu_q.push_back('{opa: 32'(k), opb: run, op: 2'd0});
      run = run + 32'(k);
    end
    out_q.push_back('{err: 1'b0, dat: run});
    for (int k = 1; k < DEPTH; k++) begin
      send_token(1'b0, 32'h2B);
      serve_alu(k % 3);
    end
    send_token(1'b0, 32'h3D);
    collect_output(0);
  endtask

  task automatic test_bad_ops();
    out_q.push_back('{err: 1'b1, dat: 32'd4});
    send_token(1'b1, 32'd1);
    send_token(1'b1, 32'd2);
    send_token(1'b0, 32'h3D);
    collect_output(0);
    out_q.push_back('{err: 1'b1, dat: 32'd3});
    send_token(1'b0, 32'h2F);
    collect_output(0);
    out_q.push_back('{err: 1'b1, dat: 32'd4});
    send_token(1'b0, 32'h3D);
    collect_output(0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, c, r1;
    logic [1:0]   op1, op2;
    for (int it = 0; it < 5; it++) begin
      a   = $urandom;
      b   = $urandom;
      c   = $urandom;
      op1 = 2'($urandom_range(0, 2));
      op2 = 2'($urandom_range(0, 2));
      r1  = alu_model(a, b, op1);
      alu_q.push_back('{opa: a, opb: b, op: op1});
      alu_q.push_back('{opa: r1, opb: c, op: op2});
      out_q.push_back('{err: 1'b0, dat: alu_model(r1, c, op2)});
      send_token(1'b1, a);
      send_token(1'b1, b);
      send_token(1'b0, op_token(op1) | 32'hFFFF_FF00 & 32'h0);
      serve_alu($urandom_range(0, 3));
      send_token(1'b1, c);
      send_token(1'b0, op_token(op2));
      serve_alu($urandom_range(0, 3));
      send_token(1'b0, 32'h3D);
      collect_output($urandom_range(0, 2));
    end
  endtask

  task automatic test_out_hold();
    out_q.push_back('{err: 1'b0, dat: 32'd9});
    send_token(1'b1, 32'd9);
    send_token(1'b0, 32'h3D);
    collect_output(5);
  endtask

  task automatic test_reset_mid_alu();
    send_token(1'b1, 32'd7);
    send_token(1'b1, 32'd8);
    send_token(1'b0, 32'h2A);
    checks++;
    if (A_STB !== 1'b1 || A_OPA !== 32'd7 || A_OPB !== 32'd8 || A_OP !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pre_reset_req got stb%b %0h %0h op%0d exp stb1 7 8 op2",
               A_STB, A_OPA, A_OPB, A_OP);
    end
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (A_STB !== 1'b0 || O_SP !== 8'd0 || A_OPA !== '0 || I_ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset got stb%b sp%0d opa%0h iack%b exp stb0 sp0 opa0 iack1",
               A_STB, O_SP, A_OPA, I_ACK);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    A_RES = 32'd99;
    A_ACK = 1'b1;
    @(posedge CLK); #1;
    A_ACK = 1'b0;
    A_RES = '0;
    checks++;
    if (A_STB !== 1'b0 || O_SP !== 8'd0 || O_STB !== 1'b0 || I_ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL late_ack got stb%b sp%0d ostb%b iack%b exp stb0 sp0 ostb0 iack1",
               A_STB, O_SP, O_STB, I_ACK);
    end
    alu_q.push_back('{opa: 32'd2, opb: 32'd3, op: 2'd0});
    out_q.push_back('{err: 1'b0, dat: 32'd5});
    send_token(1'b1, 32'd2);
    send_token(1'b1, 32'd3);
    send_token(1'b0, 32'h2B);
    serve_alu(1);
    send_token(1'b0, 32'h3D);
    collect_output(0);
  endtask

  initial begin
    RST = 1'b0;
    I_DAT = '0;
    I_NUM_OR_OP = 1'b0;
    I_STB = 1'b0;
    A_ACK = 1'b0;
    A_RES = '0;
    O_ACK = 1'b0;
    test_reset();
    test_add();
    test_sub_mul();
    test_underflow_recovery();
    test_back_to_back_overflow();
    test_full_stack();
    test_bad_ops();
    test_random();
    test_out_hold();
    test_reset_mid_alu();
    checks++;
    if (alu_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got alu%0d out%0d exp 0 0", alu_q.size(), out_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
